port_egress_queue: RTL and testbench
====================================

PORT_EGRESS_QUEUE -- requirements
Module: port_egress_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue depth in packets; SHALL be a power of 2, at least 2.
REQ-002 Parameter DATA_W, default 8, packet data width.
REQ-003 Parameter ADDR_W, default 4, width of source and target fields.
REQ-004 clk  input  1  single clock; all logic SHALL be rising-edge clocked.
REQ-005 rst  input  1  reset, synchronous and active-high.
REQ-006 req_valid  input  4  per ingress port i: a packet addressed to this egress port is offered.
REQ-007 req_source  input  4*ADDR_W  source field of each offer; slice i belongs to port i.
REQ-008 req_target  input  4*ADDR_W  target field of each offer; slice i belongs to port i.
REQ-009 req_data  input  4*DATA_W  data field of each offer; slice i belongs to port i.
REQ-010 req_ready  output  4  one-hot grant; offer i is accepted in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-011 valid_out  output  1  the head packet is presented.
REQ-012 source_out, target_out  output  ADDR_W each  fields of the head packet.
REQ-013 data_out  output  DATA_W  data of the head packet.
REQ-014 ready_out  input  1  sink accepts the head packet when valid_out is also high.
REQ-015 count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 pkt_cnt  output  16  number of packets delivered on the egress side.

Function
REQ-017 Arbitration SHALL be round-robin.
- Search order: rr_ptr, rr_ptr+1, ... mod 4.
- The first port with req_valid high SHALL be granted.
REQ-018 req_ready SHALL be combinational.
- At most one bit high per cycle.
- All bits zero when no request is pending.
- All bits zero when the queue cannot accept: count==DEPTH and no pop this cycle.
REQ-019 A push while the queue is full SHALL be permitted only in a cycle where a pop also occurs.
REQ-020 On a grant to port g, rr_ptr SHALL become (g+1) mod 4 at the next edge; with no grant, rr_ptr SHALL hold.
REQ-021 A granted packet {source, target, data} SHALL be written at the write pointer and the write pointer SHALL advance.
REQ-022 Output presentation SHALL be first-word fall-through from the head entry.
- valid_out = (count != 0).
- source_out, target_out and data_out are driven from the head entry.
REQ-023 Pop SHALL occur when valid_out && ready_out; the read pointer SHALL then advance.
REQ-024 Pointers SHALL wrap modulo DEPTH with no skipped or duplicated entry.
REQ-025 Count update per cycle:
- push only: +1.
- pop only: -1.
- push and pop together: unchanged.
REQ-026 Minimum latency SHALL be 1 cycle: a packet accepted at edge N shows valid_out high after edge N when the queue was empty.
REQ-027 There SHALL be no bypass path; req_* never reaches the outputs in the same cycle.
REQ-028 While valid_out is high and ready_out is low, all egress outputs SHALL hold stable.
REQ-029 Packets SHALL leave in acceptance order, with fields unmodified.
REQ-030 pkt_cnt SHALL increment by 1 on each pop and wrap from 0xFFFF to 0.
REQ-031 No packet SHALL ever be dropped or overwritten.
- An offer not granted stays pending, with the upstream holding it.

Reset
REQ-032 While rst is high at a rising edge, at that edge:
- count, pointers, pkt_cnt and valid_out SHALL go to 0.
- rr_ptr SHALL go to 0.
REQ-033 Reset mid-operation SHALL discard all queued packets.
- req_ready SHALL be all zero during any cycle with rst high.
- Data outputs MAY hold stale values while valid_out is 0.
REQ-034 The first cycle after rst falls SHALL behave as an empty queue with rr_ptr=0.

Verification
REQ-035 Single offer: req_valid=0001, source 0, target 2, data 8'hA5, ready_out=1 -> req_ready=0001; next cycle valid_out=1 with fields {0, 2, A5}; pkt_cnt=1 after the pop.
REQ-036 Contention: req_valid=1111 held 4 cycles from reset, ready_out=1 -> grants 0001, 0010, 0100, 1000 in that order; outputs appear in source order 0, 1, 2, 3.
REQ-037 Fill and backpressure: ready_out=0, port 1 offers data 1..6 -> 4 grants (data 1..4); then req_ready=0000, count=4, and data_out holds at 1 stably.
REQ-038 Full with simultaneous pop: after REQ-037, raise ready_out for 1 cycle -> that same cycle grants data 5; count stays 4; data_out becomes 2.
REQ-039 Wrap and counter:
- Stream 20 packets with ready_out toggling every cycle -> all 20 out in order, pointers wrap at least 4 times.
- With pkt_cnt preloaded near 0xFFFF, it wraps to 0.
REQ-040 Reset mid-stream: rst=1 for 1 cycle with count=3 -> next cycle count=0, valid_out=0, rr_ptr=0; the next offer from port 3 is granted at once.

Source files
------------

// File: rtl/port_egress_queue.sv
// Egress queue for one switch port: round-robin arbitration over four ingress
// offers feeding a first-word fall-through FIFO of {source, target, data} packets.
`timescale 1ns/1ps
module port_egress_queue #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [3:0]                req_valid,
  input  logic [4*ADDR_W-1:0]       req_source,
  input  logic [4*ADDR_W-1:0]       req_target,
  input  logic [4*DATA_W-1:0]       req_data,
  output logic [3:0]                req_ready,
  output logic                      valid_out,
  output logic [ADDR_W-1:0]         source_out,
  output logic [ADDR_W-1:0]         target_out,
  output logic [DATA_W-1:0]         data_out,
  input  logic                      ready_out,
  output logic [$clog2(DEPTH):0]    count,
  output logic [15:0]               pkt_cnt
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2*ADDR_W + DATA_W;

  logic [ENT_W-1:0] mem_q [DEPTH];
  logic [ENT_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;
  logic [15:0]      pkt_cnt_q, pkt_cnt_d;

  logic             pop, push, can_accept, found;
  logic [1:0]       gnt_idx, idx;
  logic [ENT_W-1:0] wr_entry;

  always_comb begin
    pop        = (count_q != '0) && ready_out;
    // A full queue still accepts when the head leaves in the same cycle.
    can_accept = !rst && ((count_q != CNT_W'(DEPTH)) || pop);

    found   = 1'b0;
    gnt_idx = rr_ptr_q;
    idx     = rr_ptr_q;
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr_q + 2'(k);
      if (!found && req_valid[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end

    push      = found && can_accept;
    req_ready = push ? (4'b0001 << gnt_idx) : 4'b0000;
    wr_entry  = {req_source[int'(gnt_idx)*ADDR_W +: ADDR_W],
                 req_target[int'(gnt_idx)*ADDR_W +: ADDR_W],
                 req_data[int'(gnt_idx)*DATA_W +: DATA_W]};

    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = wr_entry;

    wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    rr_ptr_d  = push ? gnt_idx + 2'd1 : rr_ptr_q;
    pkt_cnt_d = pop  ? pkt_cnt_q + 16'd1 : pkt_cnt_q;

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rr_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rr_ptr_q  <= rr_ptr_d;
      pkt_cnt_q <= pkt_cnt_d;
    end
  end

  // Packet storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign valid_out                          = (count_q != '0);
  assign {source_out, target_out, data_out} = mem_q[rd_ptr_q];
  assign count                              = count_q;
  assign pkt_cnt                            = pkt_cnt_q;
endmodule

// File: tb/tb_port_egress_queue.sv
// Directed bench for port_egress_queue: occupancy model plus an in-order
// scoreboard of accepted packets compared against the head on every pop.
`timescale 1ns/1ps
module tb_port_egress_queue;
  localparam int DEPTH  = 4;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int ENT_W  = 2*ADDR_W + DATA_W;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [3:0]             req_valid;
  logic [4*ADDR_W-1:0]    req_source, req_target;
  logic [4*DATA_W-1:0]    req_data;
  logic [3:0]             req_ready;
  logic                   valid_out;
  logic [ADDR_W-1:0]      source_out, target_out;
  logic [DATA_W-1:0]      data_out;
  logic                   ready_out;
  logic [$clog2(DEPTH):0] count;
  logic [15:0]            pkt_cnt;

  logic [ADDR_W-1:0] src [4];
  logic [ADDR_W-1:0] tgt [4];
  logic [DATA_W-1:0] dat [4];

  assign req_source = {src[3], src[2], src[1], src[0]};
  assign req_target = {tgt[3], tgt[2], tgt[1], tgt[0]};
  assign req_data   = {dat[3], dat[2], dat[1], dat[0]};

  port_egress_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_source(req_source), .req_target(req_target),
    .req_data(req_data), .req_ready(req_ready),
    .valid_out(valid_out), .source_out(source_out), .target_out(target_out),
    .data_out(data_out), .ready_out(ready_out),
    .count(count), .pkt_cnt(pkt_cnt)
  );

  always #5 clk = ~clk;

  int               checks = 0;
  int               errors = 0;
  int               mcount = 0;
  logic [15:0]      exp_pkt = '0;
  logic [ENT_W-1:0] sb [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Checks one cycle at the falling edge; exp_rdy is the grant the bench expects.
  task automatic step(input logic [3:0] exp_rdy);
    logic             pop_m;
    logic [ENT_W-1:0] e;
    int               g;
    @(negedge clk);
    pop_m = (mcount != 0) && ready_out;
    check("req_ready", 32'(req_ready), 32'(exp_rdy));
    check("valid_out", 32'(valid_out), 32'(mcount != 0));
    check("count", 32'(count), 32'(mcount));
    check("pkt_cnt", 32'(pkt_cnt), 32'(exp_pkt));
    if (pop_m) begin
      e = sb.pop_front();
      check("head", 32'({source_out, target_out, data_out}), 32'(e));
      exp_pkt = exp_pkt + 16'd1;
    end
    if (exp_rdy != 4'b0000) begin
      g = 0;
      for (int i = 0; i < 4; i++) if (exp_rdy[i]) g = i;
      sb.push_back({src[g], tgt[g], dat[g]});
    end
    mcount = mcount + ((exp_rdy != 4'b0000) ? 1 : 0) - (pop_m ? 1 : 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    check("rdy_in_rst", 32'(req_ready), 32'h0);
    adv();
    rst = 1'b0;
    mcount  = 0;
    exp_pkt = '0;
    sb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int sent;
    rst = 1'b1;
    ready_out = 1'b0;
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      src[i] = ADDR_W'(i); tgt[i] = '0; dat[i] = '0;
    end
    do_reset();
    req_valid = 4'b0000;
    step(4'b0000);
    adv();

    // Single offer from port 0
    req_valid = 4'b0001; src[0] = 4'd0; tgt[0] = 4'd2; dat[0] = 8'hA5; ready_out = 1'b1;
    step(4'b0001);
    check("t1_no_bypass", 32'(valid_out), 32'h0);
    adv();
    req_valid = 4'b0000;
    step(4'b0000);
    check("t1_src", 32'(source_out), 32'h0);
    check("t1_tgt", 32'(target_out), 32'h2);
    check("t1_data", 32'(data_out), 32'hA5);
    adv();
    step(4'b0000);
    check("t1_pkt_cnt", 32'(pkt_cnt), 32'h1);
    adv();

    // Contention from reset: rr_ptr was left at 1 above, reset must clear it
    do_reset();
    for (int i = 0; i < 4; i++) begin
      src[i] = ADDR_W'(i); tgt[i] = ADDR_W'(3 - i); dat[i] = DATA_W'(8'h10 + i);
    end
    req_valid = 4'b1111; ready_out = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(4'b0001 << i);
      adv();
    end
    req_valid = 4'b0000;
    step(4'b0000); adv();
    step(4'b0000); adv();

    // Fill with backpressure, then full-with-pop
    do_reset();
    ready_out = 1'b0; req_valid = 4'b0010; src[1] = 4'd1; tgt[1] = 4'd3;
    for (int d = 1; d <= 4; d++) begin
      dat[1] = DATA_W'(d);
      step(4'b0010);
      adv();
    end
    dat[1] = 8'd5;
    step(4'b0000);
    check("t3_hold_a", 32'(data_out), 32'h1);
    adv();
    step(4'b0000);
    check("t3_hold_b", 32'(data_out), 32'h1);
    adv();
    ready_out = 1'b1;
    step(4'b0010);
    adv();
    ready_out = 1'b0; dat[1] = 8'd6;
    step(4'b0000);
    check("t4_count", 32'(count), 32'h4);
    check("t4_data", 32'(data_out), 32'h2);
    adv();
    ready_out = 1'b1;
    step(4'b0010);
    adv();
    req_valid = 4'b0000;
    for (int i = 0; i < 5; i++) begin
      step(4'b0000);
      adv();
    end

    // Stream 20 packets from port 2 with ready_out toggling
    src[2] = 4'd2; tgt[2] = 4'd1; sent = 0; ready_out = 1'b0;
    for (int cyc = 0; cyc < 200 && (sent < 20 || mcount != 0); cyc++) begin
      ready_out = ~ready_out;
      req_valid = (sent < 20) ? 4'b0100 : 4'b0000;
      dat[2] = DATA_W'(8'h40 + sent);
      acc = (sent < 20) && (mcount < DEPTH || (mcount != 0 && ready_out));
      step(acc ? 4'b0100 : 4'b0000);
      if (acc) sent++;
      adv();
    end
    step(4'b0000);
    check("t5_drained", 32'(count), 32'h0);
    adv();

    // Reset with three packets queued
    do_reset();
    ready_out = 1'b0; req_valid = 4'b0001; src[0] = 4'd0; tgt[0] = 4'd1;
    for (int d = 0; d < 3; d++) begin
      dat[0] = DATA_W'(8'h70 + d);
      step(4'b0001);
      adv();
    end
    req_valid = 4'b0000;
    step(4'b0000);
    check("t6_count3", 32'(count), 32'h3);
    adv();
    do_reset();
    req_valid = 4'b1000; src[3] = 4'd3; tgt[3] = 4'd0; dat[3] = 8'hC3;
    step(4'b1000);
    check("t6_empty", 32'(valid_out), 32'h0);
    adv();
    req_valid = 4'b0000; ready_out = 1'b1;
    step(4'b0000);
    check("t6_data", 32'(data_out), 32'hC3);
    adv();

    // pkt_cnt wrap: one push per edge, one pop per edge after the first
    do_reset();
    req_valid = 4'b0001; dat[0] = 8'h5A; ready_out = 1'b1;
    repeat (65536) @(posedge clk);
    @(negedge clk);
    check("t7_cnt_ffff", 32'(pkt_cnt), 32'hFFFF);
    check("t7_count", 32'(count), 32'h1);
    @(posedge clk);
    @(negedge clk);
    check("t7_cnt_wrap", 32'(pkt_cnt), 32'h0);
    @(posedge clk);
    #1;
    req_valid = 4'b0000;
    do_reset();
    step(4'b0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
